// File: rtl/wb_merge.sv
// Writeback merge: ALU results win the RF port, LSU results queue in a FIFO.
// Optional WB_FWD_EN adds a combinational forwarding lookup over rf_* and the FIFO.
module wb_merge #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_wb_vld,
  input  logic [4:0]      alu_wb_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic            lsu_wb_vld,
  output logic            lsu_wb_rdy,
  input  logic [4:0]      lsu_wb_addr,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [CW-1:0]   q_count,
`ifdef WB_FWD_EN
  input  logic [4:0]      fwd_raddr,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            wb_stall
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

  logic [4:0]      addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic alu_take, empty, accept, pop, bypass, push;

  assign lsu_wb_rdy = cnt_q < DEPTH_C;
  assign wb_stall   = cnt_q >= STALL_C;
  assign q_count    = cnt_q;
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;

  assign alu_take = alu_wb_vld && (alu_wb_addr != 5'd0);
  assign empty    = cnt_q == '0;
  assign accept   = lsu_wb_vld && lsu_wb_rdy;
  assign pop      = !alu_take && !empty;
  assign bypass   = !alu_take && empty && accept;
  assign push     = accept && !bypass;

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    // x0 results claim their slot but never touch the write port
    unique case (1'b1)
      alu_take: begin
        we_d    = 1'b1;
        waddr_d = alu_wb_addr;
        wdata_d = alu_wb_data;
      end
      pop: begin
        we_d = addr_mem[rd_q] != 5'd0;
        if (we_d) begin
          waddr_d = addr_mem[rd_q];
          wdata_d = data_mem[rd_q];
        end
      end
      bypass: begin
        we_d = lsu_wb_addr != 5'd0;
        if (we_d) begin
          waddr_d = lsu_wb_addr;
          wdata_d = lsu_wb_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_q] <= lsu_wb_addr;
      data_mem[wr_q] <= lsu_wb_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == DEPTH_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !push && cnt_q == '0));

`ifdef WB_FWD_EN
  logic [PW-1:0] fidx;

  // Walk oldest to newest so the newest match overrides
  always_comb begin
    fidx     = '0;
    fwd_hit  = we_q && (waddr_q == fwd_raddr);
    fwd_data = wdata_q;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rd_q + PW'(i);
      if (CW'(i) < cnt_q && addr_mem[fidx] == fwd_raddr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fidx];
      end
    end
    if (fwd_raddr == 5'd0) fwd_hit = 1'b0;
  end
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Randomized bench for wb_merge against a queue-based writeback model.
// Define WB_FWD_EN on both files to also exercise the forwarding lookup.
module tb_wb_merge;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_wb_vld;
  logic [4:0]      alu_wb_addr;
  logic [XLEN-1:0] alu_wb_data;
  logic            lsu_wb_vld;
  logic            lsu_wb_rdy;
  logic [4:0]      lsu_wb_addr;
  logic [XLEN-1:0] lsu_wb_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [CW-1:0]   q_count;
  logic            wb_stall;
`ifdef WB_FWD_EN
  logic [4:0]      fwd_raddr;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_merge #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_vld(alu_wb_vld), .alu_wb_addr(alu_wb_addr),
    .alu_wb_data(alu_wb_data),
    .lsu_wb_vld(lsu_wb_vld), .lsu_wb_rdy(lsu_wb_rdy),
    .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_count(q_count),
`ifdef WB_FWD_EN
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .wb_stall(wb_stall)
  );

  typedef struct {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  int              n_cmp = 0;
  int              n_bad = 0;
  bit              last_acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mwrite(input logic [4:0] a, input logic [XLEN-1:0] d);
    m_we = (a != 0);
    if (a != 0) begin
      m_addr = a;
      m_data = d;
    end
  endtask

  // One cycle: drive at negedge, check state outputs, step model, check rf
  task automatic step(input bit av, input logic [4:0] aa,
                      input logic [XLEN-1:0] ad, input bit lv,
                      input logic [4:0] la, input logic [XLEN-1:0] ld);
    int  sz;
    bit  acc;
    ent_t e;
    @(negedge clk);
    alu_wb_vld = av; alu_wb_addr = aa; alu_wb_data = ad;
    lsu_wb_vld = lv; lsu_wb_addr = la; lsu_wb_data = ld;
    sz = mq.size();
    #1;
    chk("q_count", 64'(q_count), 64'(sz));
    chk("lsu_rdy", 64'(lsu_wb_rdy), 64'(sz < DEPTH));
    chk("wb_stall", 64'(wb_stall), 64'(sz >= DEPTH - 1));
    acc = lv && (sz < DEPTH);
    m_we = 1'b0;
    if (av && aa != 0) begin
      mwrite(aa, ad);
      if (acc) mq.push_back('{la, ld});
    end else if (sz > 0) begin
      e = mq.pop_front();
      mwrite(e.addr, e.data);
      if (acc) mq.push_back('{la, ld});
    end else if (acc) begin
      mwrite(la, ld);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      chk("rf_wdata", rf_wdata, m_data);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_wb_vld = 0; lsu_wb_vld = 0;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_we = 0; m_addr = 0; m_data = 0;
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_qcnt", 64'(q_count), 64'd0);
    chk("rst_rdy", 64'(lsu_wb_rdy), 64'd1);
    chk("rst_stall", 64'(wb_stall), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

`ifdef WB_FWD_EN
  task automatic fwd_chk(input logic [4:0] ra);
    bit hit = 0;
    logic [XLEN-1:0] d = '0;
    fwd_raddr = ra;
    #1;
    if (m_we && m_addr == ra) begin hit = 1; d = m_data; end
    foreach (mq[i]) if (mq[i].addr == ra) begin hit = 1; d = mq[i].data; end
    if (ra == 0) hit = 0;
    chk("fwd_hit", 64'(fwd_hit), 64'(hit));
    if (hit) chk("fwd_data", fwd_data, d);
  endtask
`endif

  initial begin
    int k, guard;
    rst = 1'b1;
    alu_wb_vld = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lsu_wb_vld = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
`ifdef WB_FWD_EN
    fwd_raddr = 0;
`endif
    repeat (2) @(negedge clk);
    do_reset();

    // ALU write, then LSU bypass
    step(1, 5, 64'hDEAD, 0, 0, 0);
    step(0, 0, 0, 1, 7, 64'h11);
    idle(1);

    // ALU busy 6 cycles while LSU offers 1..5, then drain
    k = 1; guard = 0;
    while ((k <= 5 || mq.size() > 0) && guard < 40) begin
      step(guard < 6, 5'd20, 64'(guard), k <= 5, 5'(k), 64'(k * 16'h100));
      if (last_acc) k++;
      guard++;
    end
    chk("drain_done", 64'(guard < 40), 64'd1);

    // ALU x0 lets FIFO pop; LSU x0 accepted but writes nothing
    step(1, 3, 64'h33, 1, 9, 64'h99);
    step(1, 0, 64'hBAD, 0, 0, 0);
    step(0, 0, 0, 1, 0, 64'h77);
    idle(1);

`ifdef WB_FWD_EN
    step(1, 4, 64'h1, 1, 3, 64'hA);
    step(1, 4, 64'h2, 1, 3, 64'hB);
    @(negedge clk);
    alu_wb_vld = 0; lsu_wb_vld = 0;
    fwd_chk(3);
    fwd_chk(4);
    fwd_chk(0);
    idle(3);
`endif

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) step(1, 6, 64'(i), 1, 5'(10 + i), 64'(i));
    do_reset();
    idle(4);

    // Random phases with varying ALU pressure
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 120; c++) begin
        step($urandom_range(99) < 20 * ph,
             ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
             {$urandom, $urandom},
             $urandom_range(99) < 60,
             ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
             {$urandom, $urandom});
`ifdef WB_FWD_EN
        fwd_chk(5'($urandom_range(3)));
`endif
        if ($urandom_range(199) == 0) do_reset();
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
